// File: rtl/sa2_cache_if.sv
// Pipeline-side read port, flush control and memory refill port of the
// 2-way set-associative read cache.
interface sa2_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              flush;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, flush, mem_valid, mem_rdata,
    input  cpu_ready, cpu_valid, cpu_rdata, busy, mem_req, mem_addr
  );

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_valid, mem_rdata,
    output cpu_ready, cpu_valid, cpu_rdata, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/sa2_cache.sv
// 2-way set-associative read cache with one LRU bit per set, word-serial
// miss refill and a set-sweeping flush that also runs after every reset.
module sa2_cache #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int SETS            = 1024
) (
  input  logic      CLK,
  input  logic      RESETN,
  sa2_cache_if.slave bus
);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W  = $clog2(SETS);
  localparam int BLK_W  = OFF_W + BYTE_W;
  localparam int TAG_W  = ADDR_W - IDX_W - BLK_W;

  typedef enum logic [1:0] {FLUSH, IDLE, REFILL, RESP} state_t;
  state_t state, state_nxt;

  logic [1:0]        valid_q [SETS];
  logic              lru_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [DATA_W-1:0] data_q  [2][SETS][WORDS_PER_BLOCK];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_word;
  logic              hit0, hit1, hit, hit_way, accept, victim_nxt;

  logic [ADDR_W-BLK_W-1:0] blk_q;
  logic [OFF_W-1:0]  word_q, beat_q;
  logic              victim_q, flush_pend_q;
  logic [DATA_W-1:0] capt_q;
  logic [IDX_W-1:0]  flush_cnt_q;
  logic [TAG_W-1:0]  l_tag;
  logic [IDX_W-1:0]  l_idx;
  logic              beat_hit, last_beat;

  // Byte-offset bits never select anything; the reduction keeps them visibly consumed.
  wire unused_bits = ^bus.cpu_addr;

  assign req_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = bus.cpu_addr[BLK_W +: IDX_W];
  assign req_word = bus.cpu_addr[BYTE_W +: OFF_W];

  assign hit0       = valid_q[req_idx][0] && (tag_q[0][req_idx] == req_tag);
  assign hit1       = valid_q[req_idx][1] && (tag_q[1][req_idx] == req_tag);
  assign hit        = hit0 || hit1;
  assign hit_way    = hit1;
  assign accept     = bus.cpu_req && bus.cpu_ready;
  assign victim_nxt = !valid_q[req_idx][0] ? 1'b0 :
                      !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

  assign l_tag     = blk_q[ADDR_W-BLK_W-1 -: TAG_W];
  assign l_idx     = blk_q[IDX_W-1:0];
  assign beat_hit  = (state == REFILL) && bus.mem_valid;
  assign last_beat = beat_hit && (beat_q == OFF_W'(WORDS_PER_BLOCK - 1));
  assign bus.mem_addr = {blk_q, {BLK_W{1'b0}}};

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= FLUSH;
    else         state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FLUSH:  if (flush_cnt_q == IDX_W'(SETS - 1)) state_nxt = IDLE;
      IDLE:   if (bus.flush)            state_nxt = FLUSH;
              else if (accept && !hit)  state_nxt = REFILL;
      REFILL: if (last_beat)            state_nxt = RESP;
      RESP:   state_nxt = (flush_pend_q || bus.flush) ? FLUSH : IDLE;
      default: state_nxt = FLUSH;
    endcase
  end

  always_comb begin
    bus.cpu_ready = (state == IDLE) && !bus.flush;
    bus.mem_req   = (state == REFILL);
    bus.busy      = (state == FLUSH);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bus.cpu_valid <= 1'b0;
      bus.cpu_rdata <= '0;
      blk_q         <= '0;
      word_q        <= '0;
      beat_q        <= '0;
      victim_q      <= 1'b0;
      capt_q        <= '0;
      flush_pend_q  <= 1'b0;
      flush_cnt_q   <= '0;
    end else begin
      bus.cpu_valid <= (accept && hit) || last_beat;
      if (accept && hit)
        bus.cpu_rdata <= data_q[hit_way][req_idx][req_word];
      else if (last_beat)
        bus.cpu_rdata <= (beat_q == word_q) ? bus.mem_rdata : capt_q;

      if (beat_hit && (beat_q == word_q)) capt_q <= bus.mem_rdata;

      if (accept && !hit) begin
        blk_q    <= bus.cpu_addr[ADDR_W-1:BLK_W];
        word_q   <= req_word;
        victim_q <= victim_nxt;
        beat_q   <= '0;
      end else if (beat_hit) begin
        beat_q <= beat_q + OFF_W'(1);
      end

      // Counter wraps to zero on the last set, ready for the next sweep.
      if (state == FLUSH) flush_cnt_q <= flush_cnt_q + IDX_W'(1);

      if (state == FLUSH)
        flush_pend_q <= 1'b0;
      else if (bus.flush && (state == REFILL || state == RESP))
        flush_pend_q <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; valid/lru are cleared by the flush sweep that follows reset.
  always_ff @(posedge CLK) begin
    if (state == FLUSH) begin
      valid_q[flush_cnt_q] <= 2'b00;
      lru_q[flush_cnt_q]   <= 1'b0;
    end else if (accept && hit) begin
      lru_q[req_idx] <= ~hit_way;
    end else if (last_beat) begin
      valid_q[l_idx][victim_q] <= 1'b1;
      lru_q[l_idx]             <= ~victim_q;
      tag_q[victim_q][l_idx]   <= l_tag;
    end
    if (beat_hit) data_q[victim_q][l_idx][beat_q] <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_sa2_cache.sv
// Directed bench for sa2_cache: data configuration (2 words, 1024 sets) and
// instruction configuration (4 words, 256 sets) side by side.
module tb_sa2_cache;
  logic CLK = 1'b0;
  logic RESETN;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  sa2_cache_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  sa2_cache_if #(.ADDR_W(32), .DATA_W(32)) bus_i ();

  sa2_cache #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_BLOCK(2), .SETS(1024)) dut0 (
    .CLK(CLK), .RESETN(RESETN), .bus(bus0.slave));
  sa2_cache #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_BLOCK(4), .SETS(256)) dut_i (
    .CLK(CLK), .RESETN(RESETN), .bus(bus_i.slave));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (bus0.cpu_ready !== 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (bus0.cpu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_timeout: cpu_ready=%b after %0d cycles, want 1", nm, bus0.cpu_ready, n);
    end
  endtask

  task automatic issue(input string nm, input logic [31:0] a);
    wait_ready(nm);
    bus0.cpu_req  = 1'b1;
    bus0.cpu_addr = a;
    @(negedge CLK);
    bus0.cpu_req  = 1'b0;
  endtask

  // Read one address and follow it through hit or full two-beat refill.
  task automatic do_read(input string nm, input logic [31:0] a, input bit exp_hit,
                         input logic [31:0] exp_data, input logic [31:0] b0, input logic [31:0] b1,
                         input bit gap, input bit flush_mid);
    issue(nm, a);
    vectors++;
    if (exp_hit) begin
      if ({bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata} !== {1'b1, 1'b0, exp_data}) begin
        miscompares++;
        $display("FAIL %s_hit: valid=%b mem_req=%b rdata=%h, want 1 0 %h",
                 nm, bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata, exp_data);
      end
    end else begin
      if ({bus0.mem_req, bus0.cpu_valid, bus0.mem_addr} !== {1'b1, 1'b0, a & 32'hFFFF_FFF8}) begin
        miscompares++;
        $display("FAIL %s_miss_req: mem_req=%b valid=%b mem_addr=%h, want 1 0 %h",
                 nm, bus0.mem_req, bus0.cpu_valid, bus0.mem_addr, a & 32'hFFFF_FFF8);
      end
      bus0.mem_valid = 1'b1;
      bus0.mem_rdata = b0;
      bus0.flush     = flush_mid;
      @(negedge CLK);
      bus0.flush = 1'b0;
      if (gap) begin
        bus0.mem_valid = 1'b0;
        bus0.mem_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        vectors++;
        if ({bus0.mem_req, bus0.cpu_valid, bus0.mem_addr} !== {1'b1, 1'b0, a & 32'hFFFF_FFF8}) begin
          miscompares++;
          $display("FAIL %s_gap: mem_req=%b valid=%b mem_addr=%h, want 1 0 %h",
                   nm, bus0.mem_req, bus0.cpu_valid, bus0.mem_addr, a & 32'hFFFF_FFF8);
        end
      end
      bus0.mem_valid = 1'b1;
      bus0.mem_rdata = b1;
      @(negedge CLK);
      bus0.mem_valid = 1'b0;
      vectors++;
      if ({bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata} !== {1'b1, 1'b0, exp_data}) begin
        miscompares++;
        $display("FAIL %s_resp: valid=%b mem_req=%b rdata=%h, want 1 0 %h",
                 nm, bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata, exp_data);
      end
    end
    @(negedge CLK);
    vectors++;
    if ({bus0.cpu_valid, bus0.cpu_rdata} !== {1'b0, exp_data}) begin
      miscompares++;
      $display("FAIL %s_hold: valid=%b rdata=%h, want 0 %h", nm, bus0.cpu_valid, bus0.cpu_rdata, exp_data);
    end
    if (flush_mid) begin
      vectors++;
      if (bus0.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_pending_flush: busy=%b, want 1", nm, bus0.busy);
      end
    end
  endtask

  // Count negedges with cpu_ready low, starting from a just-released reset.
  task automatic count_flush(input string nm, output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (bus0.cpu_ready !== 1'b1 && n < 3000) begin
      if (bus0.cpu_valid !== 1'b0) pulses++;
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (n != 1024 || bus0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_flush_len: ready low %0d cycles busy=%b, want 1024 0", nm, n, bus0.busy);
    end
  endtask

  task automatic test_reset();
    int n, p;
    #12;
    vectors++;
    if ({bus0.cpu_ready, bus0.cpu_valid, bus0.cpu_rdata, bus0.mem_req, bus0.mem_addr, bus0.busy}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state_d: ready=%b valid=%b rdata=%h mem_req=%b mem_addr=%h busy=%b, want 0 0 0 0 0 1",
               bus0.cpu_ready, bus0.cpu_valid, bus0.cpu_rdata, bus0.mem_req, bus0.mem_addr, bus0.busy);
    end
    vectors++;
    if ({bus_i.cpu_ready, bus_i.cpu_valid, bus_i.cpu_rdata, bus_i.mem_req, bus_i.mem_addr, bus_i.busy}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state_i: ready=%b valid=%b rdata=%h mem_req=%b mem_addr=%h busy=%b, want 0 0 0 0 0 1",
               bus_i.cpu_ready, bus_i.cpu_valid, bus_i.cpu_rdata, bus_i.mem_req, bus_i.mem_addr, bus_i.busy);
    end
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    count_flush("reset", n, p);
  endtask

  task automatic test_first_miss();
    do_read("first_miss", 32'h0000_1008, 1'b0, 32'hAAAA_0000, 32'hAAAA_0000, 32'hBBBB_0001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    wait_ready("b2b");
    bus0.cpu_req  = 1'b1;
    bus0.cpu_addr = 32'h0000_100C;
    @(negedge CLK);
    vectors++;
    if ({bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata} !== {1'b1, 1'b0, 32'hBBBB_0001}) begin
      miscompares++;
      $display("FAIL b2b_first: valid=%b mem_req=%b rdata=%h, want 1 0 bbbb0001",
               bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata);
    end
    bus0.cpu_addr = 32'h0000_1008;
    @(negedge CLK);
    bus0.cpu_req = 1'b0;
    vectors++;
    if ({bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata} !== {1'b1, 1'b0, 32'hAAAA_0000}) begin
      miscompares++;
      $display("FAIL b2b_second: valid=%b mem_req=%b rdata=%h, want 1 0 aaaa0000",
               bus0.cpu_valid, bus0.mem_req, bus0.cpu_rdata);
    end
    @(negedge CLK);
    vectors++;
    if ({bus0.cpu_valid, bus0.mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle: valid=%b mem_req=%b, want 0 0", bus0.cpu_valid, bus0.mem_req);
    end
  endtask

  task automatic test_lru();
    // Stray refill beats while idle must not disturb stored blocks.
    bus0.mem_valid = 1'b1;
    bus0.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge CLK);
    bus0.mem_valid = 1'b0;
    do_read("stray_beat", 32'h0000_100C, 1'b1, 32'hBBBB_0001, 32'h0, 32'h0, 1'b0, 1'b0);
    do_read("lru_fill_w1", 32'h0000_3008, 1'b0, 32'h3008_0000, 32'h3008_0000, 32'h3008_0001, 1'b1, 1'b0);
    do_read("lru_hit_1008", 32'h0000_1008, 1'b1, 32'hAAAA_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    do_read("lru_miss_5008", 32'h0000_500C, 1'b0, 32'h5008_0001, 32'h5008_0000, 32'h5008_0001, 1'b0, 1'b0);
    do_read("lru_miss_3008", 32'h0000_3008, 1'b0, 32'h3008_0000, 32'h3008_0000, 32'h3008_0001, 1'b0, 1'b0);
    do_read("lru_hit_5008", 32'h0000_5008, 1'b1, 32'h5008_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    do_read("lru_miss_1008", 32'h0000_100C, 1'b0, 32'hBBBB_0001, 32'hAAAA_0000, 32'hBBBB_0001, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    int n = 0;
    wait_ready("flush");
    bus0.flush    = 1'b1;
    bus0.cpu_req  = 1'b1;
    bus0.cpu_addr = 32'h0000_1008;
    #1;
    vectors++;
    if (bus0.cpu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_priority: cpu_ready=%b, want 0", bus0.cpu_ready);
    end
    @(negedge CLK);
    bus0.flush   = 1'b0;
    bus0.cpu_req = 1'b0;
    vectors++;
    if ({bus0.busy, bus0.mem_req, bus0.cpu_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL flush_start: busy=%b mem_req=%b valid=%b, want 1 0 0", bus0.busy, bus0.mem_req, bus0.cpu_valid);
    end
    while (bus0.busy === 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (n != 1024 || bus0.cpu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_len: busy %0d cycles ready=%b, want 1024 1", n, bus0.cpu_ready);
    end
    do_read("post_flush", 32'h0000_1008, 1'b0, 32'hAAAA_0000, 32'hAAAA_0000, 32'hBBBB_0001, 1'b0, 1'b1);
    do_read("post_pending", 32'h0000_1008, 1'b0, 32'hAAAA_0000, 32'hAAAA_0000, 32'hBBBB_0001, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_refill();
    int n, p;
    issue("rst_mid", 32'h0000_7008);
    vectors++;
    if (bus0.mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_req: mem_req=%b, want 1", bus0.mem_req);
    end
    bus0.mem_valid = 1'b1;
    bus0.mem_rdata = 32'h7008_0000;
    @(negedge CLK);
    bus0.mem_valid = 1'b0;
    #2 RESETN = 1'b0;
    #1;
    vectors++;
    if ({bus0.mem_req, bus0.cpu_valid, bus0.busy, bus0.cpu_ready} !== 4'b0010) begin
      miscompares++;
      $display("FAIL rst_mid_async: mem_req=%b valid=%b busy=%b ready=%b, want 0 0 1 0",
               bus0.mem_req, bus0.cpu_valid, bus0.busy, bus0.cpu_ready);
    end
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    count_flush("rst_mid", n, p);
    vectors++;
    if (p != 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_valid: %0d cpu_valid pulses, want 0", p);
    end
    do_read("rst_mid_after", 32'h0000_1008, 1'b0, 32'hAAAA_0000, 32'hAAAA_0000, 32'hBBBB_0001, 1'b0, 1'b0);
  endtask

  task automatic test_icache();
    int n = 0;
    while (bus_i.cpu_ready !== 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    bus_i.cpu_req  = 1'b1;
    bus_i.cpu_addr = 32'h0000_0A38;
    @(negedge CLK);
    bus_i.cpu_req = 1'b0;
    vectors++;
    if ({bus_i.mem_req, bus_i.cpu_valid, bus_i.mem_addr} !== {1'b1, 1'b0, 32'h0000_0A30}) begin
      miscompares++;
      $display("FAIL icache_miss: mem_req=%b valid=%b mem_addr=%h, want 1 0 00000a30",
               bus_i.mem_req, bus_i.cpu_valid, bus_i.mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus_i.mem_valid = 1'b1;
      bus_i.mem_rdata = 32'hC0DE_0000 + 32'(i);
      @(negedge CLK);
    end
    bus_i.mem_valid = 1'b0;
    vectors++;
    if ({bus_i.cpu_valid, bus_i.mem_req, bus_i.cpu_rdata} !== {1'b1, 1'b0, 32'hC0DE_0002}) begin
      miscompares++;
      $display("FAIL icache_resp: valid=%b mem_req=%b rdata=%h, want 1 0 c0de0002",
               bus_i.cpu_valid, bus_i.mem_req, bus_i.cpu_rdata);
    end
    @(negedge CLK);
    bus_i.cpu_req  = 1'b1;
    bus_i.cpu_addr = 32'h0000_0A3C;
    @(negedge CLK);
    bus_i.cpu_req = 1'b0;
    vectors++;
    if ({bus_i.cpu_valid, bus_i.mem_req, bus_i.cpu_rdata} !== {1'b1, 1'b0, 32'hC0DE_0003}) begin
      miscompares++;
      $display("FAIL icache_hit: valid=%b mem_req=%b rdata=%h, want 1 0 c0de0003",
               bus_i.cpu_valid, bus_i.mem_req, bus_i.cpu_rdata);
    end
  endtask

  initial begin
    RESETN          = 1'b0;
    bus0.cpu_req    = 1'b0;
    bus0.cpu_addr   = '0;
    bus0.flush      = 1'b0;
    bus0.mem_valid  = 1'b0;
    bus0.mem_rdata  = '0;
    bus_i.cpu_req   = 1'b0;
    bus_i.cpu_addr  = '0;
    bus_i.flush     = 1'b0;
    bus_i.mem_valid = 1'b0;
    bus_i.mem_rdata = '0;

    test_reset();
    test_first_miss();
    test_back_to_back();
    test_lru();
    test_flush();
    test_reset_mid_refill();
    test_icache();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sa2_cache.md
Name: sa2_cache

Overview:
- Parametrised 2-way set-associative read cache with true-LRU replacement (one LRU bit per set) and a miss-refill state machine.
- Successor to the fixed-geometry instruction/data caches. A single module covers both configurations: data cache (2 words/block, 1024 sets) and instruction cache (4 words/block, 256 sets).
- Sits between the pipeline fetch/load port and the memory interface.
- Adds a word-serial refill handshake, a set-sweeping flush, and hit/miss pipelining, none of which the earlier caches had.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, word width in bits; power of 2 and at least 8. BYTE_W = log2(DATA_W/8).
- WORDS_PER_BLOCK, 2, words per block; power of 2 and at least 2. OFF_W = log2(WORDS_PER_BLOCK).
- SETS, 1024, number of sets; power of 2. IDX_W = log2(SETS).
- Derived: TAG_W = ADDR_W - IDX_W - OFF_W - BYTE_W. Defaults give TAG_W = 19; the instruction configuration (4 words, 256 sets) gives 20.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESETN  in  1  reset, asynchronous assert, active-low.
- cpu_req  in  1  read request; accepted when cpu_req && cpu_ready.
- cpu_addr  in  ADDR_W  request address; sampled only on accept.
- cpu_ready  out  1  cache can accept a request this cycle.
- cpu_valid  out  1  single-cycle pulse; cpu_rdata holds the data for the oldest accepted request.
- cpu_rdata  out  DATA_W  read data.
- flush  in  1  invalidate-all request; single-cycle pulse sufficient.
- busy  out  1  high while flushing.
- mem_req  out  1  block refill request; held until the last beat.
- mem_addr  out  ADDR_W  block-aligned refill address (low OFF_W+BYTE_W bits are 0).
- mem_valid  in  1  one refill word per asserted cycle, in order, word 0 first.
- mem_rdata  in  DATA_W  refill word.

Behaviour:
- Address split:
  - tag = addr[ADDR_W-1 -: TAG_W]
  - index = addr[BYTE_W+OFF_W +: IDX_W]
  - word = addr[BYTE_W +: OFF_W]
- Storage per set: valid[2], tag[2], data[2][WORDS_PER_BLOCK], lru (the way to evict next).
- Reset values (asynchronous, while RESETN = 0):
  - cpu_ready = 0, cpu_valid = 0, cpu_rdata = 0.
  - mem_req = 0, mem_addr = 0.
  - busy = 1.
  - State = FLUSH, flush set counter = 0.
- States:
  - FLUSH:
    - Each cycle: clear valid[0], valid[1] and lru of set[counter], then counter++.
    - After set SETS-1, go to IDLE.
    - Duration is exactly SETS cycles; busy = 1 and cpu_ready = 0 throughout.
  - IDLE:
    - cpu_ready = !flush (combinational).
    - flush = 1: go to FLUSH; any same-cycle cpu_req is NOT accepted (flush has priority).
    - On accept with a hit in way w:
      - Next cycle: cpu_valid = 1, cpu_rdata = data[w][word], lru = ~w.
      - Stay in IDLE, so back-to-back hits sustain 1 per cycle.
    - On accept with a miss:
      - Latch address.
      - Victim = way 0 if invalid, else way 1 if invalid, else way lru.
      - Go to REFILL.
  - REFILL:
    - mem_req = 1; mem_addr = latched address with low OFF_W+BYTE_W bits zeroed, stable for the whole refill.
    - Each mem_valid beat writes data[victim][beat], beat counter++.
    - A beat whose index equals the requested word is captured for the response.
    - On beat WORDS_PER_BLOCK-1: write tag, set valid[victim] = 1, lru = ~victim, go to RESP. mem_req = 0 from the next cycle.
    - mem_valid outside REFILL is ignored.
    - flush during REFILL is held pending and taken on return to IDLE.
  - RESP:
    - One cycle: cpu_valid = 1 with the captured word, then go to IDLE (or FLUSH if a flush is pending).
- Latency, from the accept edge:
  - Hit: cpu_valid 1 cycle after accept.
  - Miss: mem_req rises 1 cycle after accept; cpu_valid 1 cycle after the last refill beat.
- cpu_ready = 0 in REFILL, RESP and FLUSH.
- cpu_valid is 0 in every cycle not listed above.
- cpu_rdata holds its last value when cpu_valid = 0.
- Reset mid-refill or mid-flush: the operation is abandoned, mem_req drops immediately (asynchronously), and a full SETS-cycle flush follows release.
- No write path; stores are handled outside this block.

Test Plan:
1. Reset release, then cpu_req at 0x0000_1008 (default parameters) -> cpu_ready low for exactly 1024 cycles; miss; mem_req = 1, mem_addr = 0x0000_1008; beats 0xAAAA0000, 0xBBBB0001 -> cpu_valid 1 cycle after beat 2, cpu_rdata = 0xAAAA0000.
2. Immediately read 0x100C then 0x1008 on consecutive cycles -> two hits; cpu_valid on two consecutive cycles with 0xBBBB0001 then 0xAAAA0000; mem_req stays 0.
3. LRU sequence, all addresses index 0x201:
   - Fill 0x1008 (way 0), then 0x3008 (way 1).
   - Read 0x1008 -> hit.
   - Read 0x5008 -> miss that evicts 0x3008.
   - Read 0x3008 -> miss that evicts 0x1008.
   - Read 0x5008 -> hit.
4. Assert flush and cpu_req on the same IDLE cycle -> request not accepted; busy = 1 for 1024 cycles; re-issued 0x1008 then misses.
5. RESETN low after the first refill beat -> mem_req = 0 without waiting for a clock edge, cpu_valid never pulses; after release, 1024 flush cycles, then 0x1008 misses again.
6. Instruction configuration (WORDS_PER_BLOCK = 4, SETS = 256): read 0x0000_0A38 -> mem_addr = 0x0000_0A30, 4 beats; cpu_rdata = beat 2; a following read of 0x0A3C hits with beat 3.
